// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM state encodings for the SPI-fed RAM controller.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    TX   = 2'b10
  } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command-in / read-data-out bundle between a command source and spi_ram_ctrl.
interface spi_ram_ctrl_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              err;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, err
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port RAM: synchronous write, one-cycle registered read, no reset.
module spi_ram_mem #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-driven RAM controller: address/data write and read commands, read data
// returned over a valid/ready handshake. err is registered: it pulses the cycle after acceptance.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter bit          AUTO_INC  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spi_ram_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(MEM_DEPTH - 1);

  generate
    if (ADDR_W > DATA_W) begin : g_bad_addr_w
      $error("spi_ram_ctrl: ADDR_W must not exceed DATA_W");
    end
    if (MEM_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("spi_ram_ctrl: MEM_DEPTH must not exceed 2**ADDR_W");
    end
  endgenerate

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_armed;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;

  cmd_e              w_op;
  logic [DATA_W-1:0] w_payload;
  logic              w_accept;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_err_nxt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_q;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LP_LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  assign w_op      = cmd_e'(bus.rx_data[DATA_W+1:DATA_W]);
  assign w_payload = bus.rx_data[DATA_W-1:0];
  assign w_accept  = bus.rx_valid && (r_state == IDLE);
  assign w_wr_ok   = {1'b0, r_wr_addr} < LP_DEPTH;
  assign w_rd_ok   = {1'b0, r_rd_addr} < LP_DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The RAM read is launched on acceptance so its registered output can be
  // captured into dout during RD, giving tx_valid two cycles after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_wr_addr;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_op)
            CMD_WR_DATA: begin
              w_mem_en  = w_wr_ok;
              w_mem_we  = 1'b1;
              w_err_nxt = !w_wr_ok;
            end
            CMD_RD_DATA: begin
              if (r_rd_armed) begin
                w_state_nxt = RD;
                w_mem_en    = w_rd_ok;
                w_mem_addr  = r_rd_addr;
                w_err_nxt   = !w_rd_ok;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      RD:      w_state_nxt = TX;
      TX:      if (bus.tx_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_rd_armed <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (w_accept) begin
        case (w_op)
          CMD_WR_ADDR: r_wr_addr <= w_payload[ADDR_W-1:0];
          CMD_WR_DATA: if (AUTO_INC) r_wr_addr <= addr_inc(r_wr_addr);
          CMD_RD_ADDR: begin
            r_rd_addr  <= w_payload[ADDR_W-1:0];
            r_rd_armed <= 1'b1;
          end
          default: ;
        endcase
      end
      if (r_state == RD) begin
        r_dout <= w_rd_ok ? w_mem_q : '0;
      end
      if ((r_state == TX) && bus.tx_ready && AUTO_INC) begin
        r_rd_addr <= addr_inc(r_rd_addr);
      end
    end
  end

  spi_ram_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_payload),
    .o_rdata (w_mem_q)
  );

  assign bus.rx_ready = (r_state == IDLE);
  assign bus.tx_valid = (r_state == TX);
  assign bus.dout     = r_dout;
  assign bus.err      = r_err;

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DATA_W, default 8, data width in bits; ADDR_W <= DATA_W SHALL hold (elaboration error otherwise).
REQ-004 Parameter MEM_DEPTH, default 256, number of words; MEM_DEPTH <= 2**ADDR_W.
REQ-005 Parameter AUTO_INC, default 1, enables address post-increment on data commands.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 rx_data  in  DATA_W+2  command word; [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
REQ-009 rx_valid  in  1  rx_data valid.
REQ-010 rx_ready  out  1  block accepts a command this cycle.
REQ-011 dout  out  DATA_W  read data.
REQ-012 tx_valid  out  1  dout valid.
REQ-013 tx_ready  in  1  consumer takes dout.
REQ-014 err  out  1  one-cycle error pulse.

Function
REQ-015 A command SHALL be accepted only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL equal (state==IDLE).
REQ-016 Opcode 00 (write address): wr_addr <= payload[ADDR_W-1:0].
REQ-017 Opcode 01 (write data): mem[wr_addr] <= payload; if AUTO_INC, wr_addr increments, wrapping from MEM_DEPTH-1 to 0.
REQ-018 Opcode 10 (read address): rd_addr <= payload[ADDR_W-1:0]; rd_armed <= 1.
REQ-019 Opcode 11 (read data) with rd_armed=1: FSM IDLE -> RD (sync memory read issued) -> TX.
REQ-020 In TX, tx_valid SHALL be 1 and dout stable until tx_ready=1; on that handshake the FSM returns to IDLE and, if AUTO_INC, rd_addr increments with the same wrap rule.
REQ-021 Latency: read-data command accepted on cycle N -> tx_valid=1 from cycle N+2; zero-wait consumer gives one read every 3 cycles.
REQ-022 Opcode 11 with rd_armed=0: no memory access, no tx_valid, err=1 for one cycle, FSM stays IDLE.
REQ-023 Any write or read address >= MEM_DEPTH: write dropped with err pulse; read returns dout=0 with tx_valid asserted normally and err pulse on acceptance.
REQ-024 dout SHALL hold its last value after the handshake until the next read completes.
REQ-025 Only IDLE accepts commands, so memory read and write SHALL never coincide; rx_data outside an accepted cycle SHALL be ignored.
REQ-026 err SHALL be 0 on every cycle not named in REQ-022/REQ-023.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, tx_valid=0, dout=0, err=0, wr_addr=0, rd_addr=0, rd_armed=0, independent of clk.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset in RD or TX SHALL abort the read with no tx handshake; rx_ready=1 on the first clock edge after rst deasserts.

Structure
REQ-030 Package spi_ram_pkg SHALL hold the opcode constants (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11) and the FSM state encoding (IDLE, RD, TX).
REQ-031 Storage SHALL be a sub-module spi_ram_mem: single-port, synchronous write, one-cycle registered read, parametrised by ADDR_W, DATA_W, MEM_DEPTH.

Verification
REQ-032 Write 00/0x10, 01/0xA5, read 10/0x10, 11 -> tx_valid at N+2, dout=0xA5, err=0.
REQ-033 AUTO_INC=1: 00/0xFE, data 0x11, 0x22, 0x33; 10/0xFE, three 11 -> dout 0x11, 0x22, 0x33 (third from address 0x00).
REQ-034 Read 11 straight after reset -> err pulse for exactly one cycle, tx_valid stays 0, rx_ready stays 1.
REQ-035 tx_ready held low 5 cycles in TX -> tx_valid and dout stable, rx_ready=0, commands ignored; handshake -> rx_ready=1 next cycle.
REQ-036 MEM_DEPTH=200: write to 0xC8 -> err pulse, memory unchanged; read 0xC8 -> dout=0, err pulse.
REQ-037 rst pulse mid-TX -> tx_valid=0 and dout=0 without a clock edge; next read of a previously written address returns stored data.
